// File: rtl/mux_4_1_pkg.sv
// rtl/mux_4_1_pkg.sv - select-code type and constants shared by the 4:1 selector
package mux_4_1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_IN0 = 2'd0;
  localparam sel_t SEL_IN1 = 2'd1;
  localparam sel_t SEL_IN2 = 2'd2;
  localparam sel_t SEL_IN3 = 2'd3;

endpackage

// File: rtl/mux_4_1_comb.sv
// rtl/mux_4_1_comb.sv - pure combinational 4:1 selector
module mux_4_1_comb
  import mux_4_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = '0;
    // An unknown select falls to the zero default; synthesis treats it as don't-care.
    case (sel)
      SEL_IN0: out = in0;
      SEL_IN1: out = in1;
      SEL_IN2: out = in2;
      SEL_IN3: out = in3;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/mux_4_1.sv
// rtl/mux_4_1.sv - 4:1 selector with combinational output and an enabled capture register
module mux_4_1
  import mux_4_1_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int REG_EN_DEFAULT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
  output logic             out_vld
);

  // REG_EN_DEFAULT only documents how en is expected to be tied; it has no logic effect.
  if (REG_EN_DEFAULT != 0 && REG_EN_DEFAULT != 1) begin : g_bad_reg_en_default
    $error("REG_EN_DEFAULT must be 0 or 1");
  end

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] data_q, data_d;
  sel_t             code_q, code_d;
  logic             vld_q,  vld_d;

  mux_4_1_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .sel(sel),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .out(sel_data)
  );

  assign out = sel_data;

  always_comb begin
    data_d = data_q;
    code_d = code_q;
    vld_d  = vld_q;
    if (en) begin
      data_d = sel_data;
      code_d = sel;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      code_q <= SEL_IN0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      code_q <= code_d;
      vld_q  <= vld_d;
    end
  end

  assign out_q   = data_q;
  assign sel_q   = code_q;
  assign out_vld = vld_q;

endmodule

// File: tb/tb_mux_4_1.sv
// tb/tb_mux_4_1.sv - directed self-checking bench for mux_4_1
module tb_mux_4_1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] sel;

  logic       in0, in1, in2, in3;
  logic       out, out_q, out_vld;
  logic [1:0] sel_q;

  logic [7:0] w0, w1, w2, w3;
  logic [7:0] wout, wout_q;
  logic [1:0] wsel_q;
  logic       wout_vld;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_4_1 #(.WIDTH(1), .REG_EN_DEFAULT(1)) dut (
    .clk(clk), .rst(rst),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .sel(sel), .en(en),
    .out(out), .out_q(out_q), .sel_q(sel_q), .out_vld(out_vld)
  );

  mux_4_1 #(.WIDTH(8), .REG_EN_DEFAULT(1)) dut_w (
    .clk(clk), .rst(rst),
    .in0(w0), .in1(w1), .in2(w2), .in3(w3),
    .sel(sel), .en(en),
    .out(wout), .out_q(wout_q), .sel_q(wsel_q), .out_vld(wout_vld)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_n(input logic a, input logic b, input logic c, input logic d);
    in0 = a; in1 = b; in2 = c; in3 = d;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; sel = 2'd0;
    set_n(0, 0, 0, 0);
    w0 = 8'h00; w1 = 8'h00; w2 = 8'h00; w3 = 8'h00;
    #1;
    check("reset_out_q",   {7'd0, out_q},   8'h00);
    check("reset_sel_q",   {6'd0, sel_q},   8'h00);
    check("reset_out_vld", {7'd0, out_vld}, 8'h00);
    check("reset_w_vld",   {7'd0, wout_vld}, 8'h00);

    // all zero, sel=0, capture
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    #1;
    check("zero_out", {7'd0, out}, 8'h00);
    clock_edge();
    check("zero_out_q",   {7'd0, out_q},   8'h00);
    check("zero_sel_q",   {6'd0, sel_q},   8'h00);
    check("zero_out_vld", {7'd0, out_vld}, 8'h01);

    // sel=1 with in0=in1=1
    set_n(1, 1, 0, 0);
    w0 = 8'h11; w1 = 8'h22; w2 = 8'h44; w3 = 8'h88;
    sel = 2'd1;
    #1;
    check("sel1_out",   {7'd0, out}, 8'h01);
    check("sel1_w_out", wout,        8'h22);
    clock_edge();
    check("sel1_out_q",   {7'd0, out_q}, 8'h01);
    check("sel1_sel_q",   {6'd0, sel_q}, 8'h01);
    check("sel1_w_out_q", wout_q,        8'h22);
    check("sel1_w_sel_q", {6'd0, wsel_q}, 8'h01);

    // in3 ignored at sel=2, then sel=3 alone
    set_n(0, 0, 0, 1);
    sel = 2'd2;
    #1;
    check("sel2_ignore_in3", {7'd0, out}, 8'h00);
    check("sel2_w_out",      wout,        8'h44);
    sel = 2'd3;
    #1;
    check("sel3_out",   {7'd0, out}, 8'h01);
    check("sel3_w_out", wout,        8'h88);
    sel = 2'd0;
    #1;
    check("sel0_w_out", wout, 8'h11);

    // non-selected toggles at sel=2
    set_n(0, 0, 0, 0);
    sel = 2'd1;
    #1;
    check("sel1_zero_out", {7'd0, out}, 8'h00);
    in2 = 1'b1; sel = 2'd2;
    #1;
    check("sel2_out", {7'd0, out}, 8'h01);
    set_n(1, 1, 1, 1);
    #1;
    check("sel2_toggle_hi", {7'd0, out}, 8'h01);
    set_n(0, 0, 1, 0);
    #1;
    check("sel2_toggle_lo", {7'd0, out}, 8'h01);

    // capture then hold with en=0
    clock_edge();
    check("cap_out_q",   {7'd0, out_q}, 8'h01);
    check("cap_sel_q",   {6'd0, sel_q}, 8'h02);
    check("cap_w_out_q", wout_q,        8'h44);
    en = 1'b0;
    set_n(0, 0, 0, 0);
    w2 = 8'h5a;
    #1;
    check("hold_out_comb", {7'd0, out}, 8'h00);
    check("hold_w_comb",   wout,        8'h5a);
    sel = 2'd0;
    clock_edge();
    clock_edge();
    clock_edge();
    check("hold_out_q",   {7'd0, out_q},   8'h01);
    check("hold_sel_q",   {6'd0, sel_q},   8'h02);
    check("hold_out_vld", {7'd0, out_vld}, 8'h01);
    check("hold_w_out_q", wout_q,          8'h44);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_q",   {7'd0, out_q},   8'h00);
    check("arst_sel_q",   {6'd0, sel_q},   8'h00);
    check("arst_out_vld", {7'd0, out_vld}, 8'h00);
    check("arst_w_out_q", wout_q,          8'h00);
    in0 = 1'b1; en = 1'b1; sel = 2'd0;
    #1;
    check("rst_out_follows", {7'd0, out}, 8'h01);
    sel = 2'd3; w3 = 8'hc3;
    #1;
    check("rst_w_follows", wout, 8'hc3);
    clock_edge();
    clock_edge();
    check("rst_hold_out_q",   {7'd0, out_q},   8'h00);
    check("rst_hold_out_vld", {7'd0, out_vld}, 8'h00);

    // release and recapture
    rst = 1'b0;
    sel = 2'd0;
    clock_edge();
    check("post_out_q",   {7'd0, out_q},    8'h01);
    check("post_sel_q",   {6'd0, sel_q},    8'h00);
    check("post_out_vld", {7'd0, out_vld},  8'h01);
    check("post_w_out_q", wout_q,           8'h11);
    check("post_w_vld",   {7'd0, wout_vld}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_4_1.md
Name: mux_4_1

Overview:
- Four-input, one-output selector; 2-bit select picks one of in0..in3.
- Primary output `out` is purely combinational, with zero latency.
- A registered copy (`out_q`, `out_vld`, `sel_q`) is provided for downstream timing closure.
- Used as a generic datapath steering leaf wherever a 4-way choice is needed.

Parameters:
- WIDTH, 1, bit width of each data input and of both data outputs.
- REG_EN_DEFAULT, 1, value the capture logic assumes for `en` when the port is tied off; documentation only, no logic effect.

Ports:
- clk  input  1  rising-edge clock for the registered path
- rst  input  1  asynchronous, active-high reset; clears all registered outputs
- in0  input  WIDTH  data input, selected when sel=0
- in1  input  WIDTH  data input, selected when sel=1
- in2  input  WIDTH  data input, selected when sel=2
- in3  input  WIDTH  data input, selected when sel=3
- sel  input  2  select code
- en  input  1  capture enable for the registered path
- out  output  WIDTH  combinational selected data
- out_q  output  WIDTH  registered selected data
- sel_q  output  2  select code captured with out_q
- out_vld  output  1  high when out_q holds a value captured since reset

Behaviour:
Interface:
- One clock; reset is asynchronous and active-high (clk, rst).

Combinational path:
- out = in0 / in1 / in2 / in3 for sel = 0 / 1 / 2 / 3.
- Zero latency; no dependence on clk, rst or en.
- Any sel containing X/Z drives out to all zeros. This is the default branch; synthesis treats it as don't-care.
- out changes in the same delta as any change on sel or on the selected input.
- Changes on non-selected inputs have no effect on out.

Registered path:
- On rst assertion, immediately and independent of clk: out_q=0, sel_q=0, out_vld=0.
- Registers hold these values while rst is high.
- On a rising clk edge with rst low and en=1: out_q <= current out, sel_q <= sel, out_vld <= 1.
  - Latency from input to out_q is 1 cycle.
- On a rising clk edge with rst low and en=0: out_q, sel_q and out_vld hold.
- out_vld stays 1 until the next reset; it is never cleared by en=0.
- Reset asserted mid-operation wins over a simultaneous clk edge with en=1: the registers clear.
- Reset deassertion is synchronised by the user; the block does not add a reset synchroniser.

Width rules:
- All data paths are WIDTH bits with no extension or truncation.
- sel is always exactly 2 bits, so every code selects a valid input and there is no out-of-range case.

Decomposition:
- Shared package holds the select-code constants SEL_IN0=2'd0, SEL_IN1=2'd1, SEL_IN2=2'd2, SEL_IN3=2'd3.
- No typedefs beyond a 2-bit sel_t.
- One natural sub-module, mux_4_1_comb: the pure combinational selector, reused for `out`.
- The top adds the capture register around mux_4_1_comb.

Test Plan:
- All inputs 0, sel=0 -> out=0; after a clk edge with en=1, out_q=0, sel_q=0, out_vld=1.
- in0=1, in1=1, in2=0, in3=0, sel=1 -> out=1 in the same timestep; after a clk edge with en=1, out_q=1, sel_q=1.
- in3=1, others 0, sel=2 -> out=0 (the non-selected in3 is ignored). Then change sel to 3 only -> out=1 with no clock needed.
- All inputs 0, sel=1 -> out=0. Then in2=1, sel=2 -> out=1. Toggling in0/in1/in3 while sel=2 -> out stays 1.
- Capture out_q=1 with en=1. Then set en=0 and change inputs so out=0 -> out_q stays 1 and sel_q holds across multiple edges.
- With out_q=1 and out_vld=1, assert rst between clock edges -> out_q=0, sel_q=0, out_vld=0 immediately; out keeps following the inputs throughout reset.
